// File: rtl/issue_req_queue.sv
// issue_req_queue: 16-slot issue queue feeding an external tree selector.
// Holds dispatched instructions and wakes their sources from CDB broadcasts.
// Raises one request per ready entry and registers the granted entry as the
// issue packet.
module issue_req_queue #(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32,
    parameter int TAG_W   = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    squash,
    input  logic                    dispatch_valid,
    input  logic [XLEN-1:0]         dispatch_pc,
    input  logic [TAG_W-1:0]        dispatch_tag1,
    input  logic                    dispatch_rdy1,
    input  logic [TAG_W-1:0]        dispatch_tag2,
    input  logic                    dispatch_rdy2,
    input  logic [TAG_W-1:0]        dispatch_dest,
    output logic                    dispatch_ready,
    input  logic                    cdb_valid,
    input  logic [TAG_W-1:0]        cdb_tag,
    output logic [ENTRIES-1:0]      sel_req,
    output logic [ENTRIES*XLEN-1:0] sel_pc,
    input  logic [ENTRIES-1:0]      sel_gnt,
    output logic                    issue_valid,
    output logic [XLEN-1:0]         issue_pc,
    output logic [TAG_W-1:0]        issue_dest,
    output logic [4:0]              count
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Entry control state (reset) and entry payload (no reset needed, gated by valid)
    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] rdy1_q;
    logic [ENTRIES-1:0] rdy2_q;
    logic [XLEN-1:0]    pc_q   [ENTRIES];
    logic [TAG_W-1:0]   tag1_q [ENTRIES];
    logic [TAG_W-1:0]   tag2_q [ENTRIES];
    logic [TAG_W-1:0]   dest_q [ENTRIES];
    logic [4:0]         count_q;

    logic [ENTRIES-1:0] gnt_eff;
    logic               gnt_any;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   free_idx;
    logic               disp_fire;
    logic               disp_rdy1;
    logic               disp_rdy2;

    assign count = count_q;

    // Requests come from registered state only; empty slots show an all-ones PC
    always_comb begin
        sel_req = valid_q & rdy1_q & rdy2_q;
        sel_pc  = '1;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i]) sel_pc[i*XLEN +: XLEN] = pc_q[i];
        end
    end

    // Mask grants to requesting entries; lowest set bit wins if several are set
    always_comb begin
        gnt_eff = sel_gnt & sel_req;
        gnt_any = |gnt_eff;
        gnt_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (gnt_eff[i]) gnt_idx = IDX_W'(i);
        end
    end

    // Pick the lowest free slot at cycle start and apply CDB bypass to the new entry
    always_comb begin
        dispatch_ready = ~&valid_q;
        free_idx       = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
        disp_fire = dispatch_valid & dispatch_ready;
        disp_rdy1 = dispatch_rdy1 | (cdb_valid & (dispatch_tag1 == cdb_tag));
        disp_rdy2 = dispatch_rdy2 | (cdb_valid & (dispatch_tag2 == cdb_tag));
    end

    // Occupancy, count and issue packet; squash overrides dispatch and grant
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q     <= '0;
            count_q     <= '0;
            issue_valid <= 1'b0;
            issue_pc    <= '0;
            issue_dest  <= '0;
        end else if (squash) begin
            valid_q     <= '0;
            count_q     <= '0;
            issue_valid <= 1'b0;
        end else begin
            // grant slot is valid and dispatch slot is free, so they never collide
            if (gnt_any) valid_q[gnt_idx] <= 1'b0;
            if (disp_fire) valid_q[free_idx] <= 1'b1;
            count_q     <= count_q + 5'(disp_fire) - 5'(gnt_any);
            issue_valid <= gnt_any;
            if (gnt_any) begin
                issue_pc   <= pc_q[gnt_idx];
                issue_dest <= dest_q[gnt_idx];
            end
        end
    end

    // Payload writes and wakeup; the dispatch write lands last so it overrides a stale wakeup
    always_ff @(posedge clock) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (cdb_valid && (tag1_q[i] == cdb_tag)) rdy1_q[i] <= 1'b1;
            if (cdb_valid && (tag2_q[i] == cdb_tag)) rdy2_q[i] <= 1'b1;
        end
        if (disp_fire) begin
            pc_q[free_idx]   <= dispatch_pc;
            tag1_q[free_idx] <= dispatch_tag1;
            tag2_q[free_idx] <= dispatch_tag2;
            dest_q[free_idx] <= dispatch_dest;
            rdy1_q[free_idx] <= disp_rdy1;
            rdy2_q[free_idx] <= disp_rdy2;
        end
    end

endmodule

// File: tb/tb_issue_req_queue.sv
// Bench for issue_req_queue: directed vector table, hand sequences for
// full/squash/grant corners, then random traffic against a queue model.
module tb_issue_req_queue;

    localparam int N  = 16;
    localparam int XL = 32;
    localparam int TW = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic          squash;
    logic          dispatch_valid;
    logic [XL-1:0] dispatch_pc;
    logic [TW-1:0] dispatch_tag1;
    logic          dispatch_rdy1;
    logic [TW-1:0] dispatch_tag2;
    logic          dispatch_rdy2;
    logic [TW-1:0] dispatch_dest;
    logic          dispatch_ready;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [N-1:0]  sel_req;
    logic [N*XL-1:0] sel_pc;
    logic [N-1:0]  sel_gnt;
    logic          issue_valid;
    logic [XL-1:0] issue_pc;
    logic [TW-1:0] issue_dest;
    logic [4:0]    count;

    int tests = 0;
    int fails = 0;

    issue_req_queue #(.ENTRIES(N), .XLEN(XL), .TAG_W(TW)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .dispatch_valid(dispatch_valid), .dispatch_pc(dispatch_pc),
        .dispatch_tag1(dispatch_tag1), .dispatch_rdy1(dispatch_rdy1),
        .dispatch_tag2(dispatch_tag2), .dispatch_rdy2(dispatch_rdy2),
        .dispatch_dest(dispatch_dest), .dispatch_ready(dispatch_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .sel_req(sel_req), .sel_pc(sel_pc), .sel_gnt(sel_gnt),
        .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_dest(issue_dest),
        .count(count)
    );

    always #5 clock = ~clock;

    // protocol guard: at most one effective grant per cycle
    always @(posedge clock) begin
        if (!reset) assert ($onehot0(sel_gnt & sel_req)) else $error("multiple grants to requesting entries");
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    bit            m_v  [N];
    bit            m_r1 [N];
    bit            m_r2 [N];
    logic [XL-1:0] m_pc [N];
    logic [TW-1:0] m_t1 [N];
    logic [TW-1:0] m_t2 [N];
    logic [TW-1:0] m_d  [N];
    int            m_cnt;
    bit            m_iv;
    logic [XL-1:0] m_ipc;
    logic [TW-1:0] m_idest;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_v[i] = 0;
        m_cnt = 0; m_iv = 0; m_ipc = '0; m_idest = '0;
    endtask

    function automatic logic [N-1:0] m_req();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_v[i] && m_r1[i] && m_r2[i];
        return r;
    endfunction

    function automatic bit m_has_free();
        for (int i = 0; i < N; i++) if (!m_v[i]) return 1;
        return 0;
    endfunction

    task automatic model_step();
        logic [N-1:0] g;
        int gi, slot;
        bit fire;
        g = sel_gnt & m_req();
        if (squash) begin
            for (int i = 0; i < N; i++) m_v[i] = 0;
            m_cnt = 0; m_iv = 0;
            return;
        end
        gi = -1; slot = -1;
        for (int i = 0; i < N; i++) begin
            if (g[i] && gi < 0) gi = i;
            if (!m_v[i] && slot < 0) slot = i;
        end
        fire = dispatch_valid && (slot >= 0);
        if (cdb_valid) begin
            for (int i = 0; i < N; i++) begin
                if (m_v[i] && m_t1[i] == cdb_tag) m_r1[i] = 1;
                if (m_v[i] && m_t2[i] == cdb_tag) m_r2[i] = 1;
            end
        end
        if (gi >= 0) begin
            m_iv = 1; m_ipc = m_pc[gi]; m_idest = m_d[gi]; m_v[gi] = 0;
        end else begin
            m_iv = 0;
        end
        if (fire) begin
            m_v[slot]  = 1;
            m_pc[slot] = dispatch_pc;
            m_t1[slot] = dispatch_tag1;
            m_t2[slot] = dispatch_tag2;
            m_d[slot]  = dispatch_dest;
            m_r1[slot] = dispatch_rdy1 || (cdb_valid && dispatch_tag1 == cdb_tag);
            m_r2[slot] = dispatch_rdy2 || (cdb_valid && dispatch_tag2 == cdb_tag);
        end
        m_cnt = m_cnt + (fire ? 1 : 0) - ((gi >= 0) ? 1 : 0);
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] r;
        r = m_req();
        chk({tag, ".count"}, count, m_cnt);
        chk({tag, ".dispatch_ready"}, dispatch_ready, m_has_free());
        chk({tag, ".sel_req"}, sel_req, r);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s.sel_pc[%0d]", tag, i), sel_pc[i*XL +: XL],
                m_v[i] ? m_pc[i] : {XL{1'b1}});
        chk({tag, ".issue_valid"}, issue_valid, m_iv);
        chk({tag, ".issue_pc"}, issue_pc, m_ipc);
        chk({tag, ".issue_dest"}, issue_dest, m_idest);
    endtask

    // check outputs for current state, advance model, cross the edge, settle
    task automatic cycle(input string tag);
        check_model(tag);
        model_step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [N-1:0] lowbit(input logic [N-1:0] x);
        return x & (~x + 1'b1);
    endfunction

    task automatic idle();
        squash = 0; dispatch_valid = 0; dispatch_pc = '0;
        dispatch_tag1 = '0; dispatch_rdy1 = 0; dispatch_tag2 = '0; dispatch_rdy2 = 0;
        dispatch_dest = '0; cdb_valid = 0; cdb_tag = '0; sel_gnt = '0;
    endtask

    task automatic set_disp(input logic [XL-1:0] pc, input logic [TW-1:0] t1, input bit r1,
                            input logic [TW-1:0] t2, input bit r2, input logic [TW-1:0] d);
        dispatch_valid = 1; dispatch_pc = pc;
        dispatch_tag1 = t1; dispatch_rdy1 = r1;
        dispatch_tag2 = t2; dispatch_rdy2 = r2; dispatch_dest = d;
    endtask

    typedef struct {
        bit            dv;
        logic [XL-1:0] pc;
        logic [TW-1:0] t1;
        bit            r1;
        logic [TW-1:0] t2;
        bit            r2;
        logic [TW-1:0] dest;
        bit            cv;
        logic [TW-1:0] ct;
        bit            mirror;
        logic [N-1:0]  e_req;
        int            e_cnt;
        bit            e_iv;
        logic [XL-1:0] e_ipc;
        logic [TW-1:0] e_idest;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // expectations are the state right after the edge of each row
        tbl[0] = '{1, 32'h100, 0, 1, 0, 1, 5,  0, 0, 0, 16'h0001, 1, 0, 32'h0,   0};
        tbl[1] = '{0, 32'h0,   0, 0, 0, 0, 0,  0, 0, 1, 16'h0000, 0, 1, 32'h100, 5};
        tbl[2] = '{1, 32'h200, 7, 0, 1, 1, 9,  0, 0, 0, 16'h0000, 1, 0, 32'h100, 5};
        tbl[3] = '{0, 32'h0,   0, 0, 0, 0, 0,  0, 0, 0, 16'h0000, 1, 0, 32'h100, 5};
        tbl[4] = '{0, 32'h0,   0, 0, 0, 0, 0,  1, 7, 0, 16'h0001, 1, 0, 32'h100, 5};
        tbl[5] = '{0, 32'h0,   0, 0, 0, 0, 0,  0, 0, 1, 16'h0000, 0, 1, 32'h200, 9};
        tbl[6] = '{1, 32'h300, 8, 0, 2, 1, 10, 1, 8, 0, 16'h0001, 1, 0, 32'h200, 9};
        tbl[7] = '{1, 32'h400, 3, 0, 4, 0, 11, 1, 3, 1, 16'h0000, 1, 1, 32'h300, 10};
        tbl[8] = '{0, 32'h0,   0, 0, 0, 0, 0,  1, 4, 0, 16'h0002, 1, 0, 32'h300, 10};
        tbl[9] = '{0, 32'h0,   0, 0, 0, 0, 0,  0, 0, 1, 16'h0000, 0, 1, 32'h400, 11};

        idle();
        reset = 1;
        #3;
        model_reset();
        check_model("reset");
        @(posedge clock); #1;
        reset = 0;

        // directed vector table: basic issue, delayed wakeup, dispatch/CDB bypass
        for (int k = 0; k < 10; k++) begin
            idle();
            dispatch_valid = tbl[k].dv; dispatch_pc = tbl[k].pc;
            dispatch_tag1 = tbl[k].t1; dispatch_rdy1 = tbl[k].r1;
            dispatch_tag2 = tbl[k].t2; dispatch_rdy2 = tbl[k].r2;
            dispatch_dest = tbl[k].dest;
            cdb_valid = tbl[k].cv; cdb_tag = tbl[k].ct;
            sel_gnt = tbl[k].mirror ? lowbit(sel_req) : '0;
            cycle($sformatf("vec%0d", k));
            chk($sformatf("vec%0d.req", k), sel_req, tbl[k].e_req);
            chk($sformatf("vec%0d.cnt", k), count, tbl[k].e_cnt);
            chk($sformatf("vec%0d.iv", k), issue_valid, tbl[k].e_iv);
            chk($sformatf("vec%0d.ipc", k), issue_pc, tbl[k].e_ipc);
            chk($sformatf("vec%0d.idest", k), issue_dest, tbl[k].e_idest);
        end

        // fill all slots with no grants, drop a 17th dispatch, then free entry 3
        idle(); squash = 1; cycle("sq0");
        for (int i = 0; i < N; i++) begin
            idle(); set_disp(32'h1000 + i * 4, 0, 1, 0, 1, TW'(i)); cycle("fill");
        end
        chk("full.count", count, 16);
        chk("full.ready", dispatch_ready, 0);
        idle(); set_disp(32'hDEAD, 0, 1, 0, 1, 6'd60); cycle("drop");
        chk("drop.count", count, 16);
        idle(); set_disp(32'hBEEF, 0, 1, 0, 1, 6'd61); sel_gnt = 16'h0008;
        chk("gntfull.ready", dispatch_ready, 0);
        cycle("gntfull");
        chk("afterfree.ready", dispatch_ready, 1);
        chk("afterfree.ipc", issue_pc, 32'h100C);
        chk("afterfree.count", count, 15);
        idle(); set_disp(32'h5000, 0, 1, 0, 1, 6'd33); cycle("refill");
        chk("refill.slot3", sel_pc[3*XL +: XL], 32'h5000);
        chk("refill.count", count, 16);

        // dispatch into entry 2 while entry 0 is granted
        idle(); squash = 1; cycle("sq1");
        idle(); set_disp(32'hA0, 0, 1, 0, 1, 1); cycle("d0");
        idle(); set_disp(32'hA4, 0, 1, 0, 1, 2); cycle("d1");
        idle(); set_disp(32'hA8, 0, 1, 0, 1, 3); sel_gnt = 16'h0001; cycle("dg");
        chk("dg.count", count, 2);
        chk("dg.ipc", issue_pc, 32'hA0);
        chk("dg.req", sel_req, 16'h0006);
        chk("dg.slot0", sel_pc[XL-1:0], 32'hFFFFFFFF);
        idle(); set_disp(32'hAC, 0, 1, 0, 1, 4); cycle("d2");
        chk("reuse0.slot0", sel_pc[XL-1:0], 32'hAC);
        idle(); set_disp(32'hB0, 0, 1, 0, 1, 5); cycle("d3");
        idle(); set_disp(32'hB4, 0, 1, 0, 1, 6); cycle("d4");
        chk("pre_squash.count", count, 5);

        // squash beats same-cycle dispatch and grant
        idle(); squash = 1; set_disp(32'hC0, 0, 1, 0, 1, 7); sel_gnt = lowbit(sel_req);
        cycle("sq2");
        chk("sq.count", count, 0);
        chk("sq.req", sel_req, 16'h0000);
        chk("sq.iv", issue_valid, 0);

        // grant on a non-requesting entry is ignored
        idle(); set_disp(32'h700, 0, 1, 0, 1, 8); cycle("d5");
        idle(); sel_gnt = 16'h0004; cycle("badg");
        chk("badg.iv", issue_valid, 0);
        chk("badg.req", sel_req, 16'h0001);
        chk("badg.count", count, 1);

        // async reset between edges clears everything at once
        idle(); set_disp(32'h900, 0, 1, 0, 1, 9); sel_gnt = lowbit(sel_req); cycle("pre_rst");
        chk("pre_rst.iv", issue_valid, 1);
        idle();
        #2;
        reset = 1;
        #1;
        model_reset();
        chk("arst.count", count, 0);
        chk("arst.req", sel_req, 16'h0000);
        chk("arst.iv", issue_valid, 0);
        chk("arst.ipc", issue_pc, 0);
        chk("arst.ready", dispatch_ready, 1);
        @(posedge clock); #1;
        reset = 0;

        // random traffic against the model
        for (int c = 0; c < 600; c++) begin
            idle();
            squash = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 70)
                set_disp($urandom, TW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                         TW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), TW'($urandom));
            cdb_valid = ($urandom_range(0, 99) < 50);
            cdb_tag   = TW'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    int k, j;
                    k = $countones(sel_req);
                    if (k > 0) begin
                        j = $urandom_range(0, k - 1);
                        for (int i = 0; i < N; i++) begin
                            if (sel_req[i]) begin
                                if (j == 0) sel_gnt[i] = 1'b1;
                                j--;
                            end
                        end
                    end
                end
                5: sel_gnt = N'(1) << $urandom_range(0, N - 1);
                default: sel_gnt = '0;
            endcase
            cycle("rnd");
        end
        idle();
        check_model("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
